// File: rtl/stat_bcd_conv.sv
// Time-multiplexed binary-to-BCD converter for the four pipeline statistics counters.
// One shift-add-3 datapath walks the channels round-robin and refreshes registered packed-BCD outputs.
module stat_bcd_conv #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter logic [4*NUM_DIGITS-1:0] SAT_VALUE = 32'h9999_9999
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [31:0]               total_cycles,
  input  logic [31:0]               uncondi_branch_num,
  input  logic [31:0]               condi_branch_num,
  input  logic [31:0]               bubble_num,
  output logic [4*NUM_DIGITS-1:0]   total_cycles_bcd,
  output logic [4*NUM_DIGITS-1:0]   uncondi_branch_num_bcd,
  output logic [4*NUM_DIGITS-1:0]   condi_branch_num_bcd,
  output logic [4*NUM_DIGITS-1:0]   bubble_num_bcd,
  output logic [3:0]                bcd_valid,
  output logic [3:0]                bcd_ovf,
  output logic                      busy
);

  localparam int unsigned BIN_W      = 32;
  localparam int unsigned OUT_W      = 4 * NUM_DIGITS;
  localparam int unsigned ACC_DIGITS = NUM_DIGITS + 2;
  localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned PTR_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_bcd [NUM_CH];
  logic [NUM_CH-1:0]  r_valid;
  logic [NUM_CH-1:0]  r_ovf;
  logic               r_busy;

  logic [BIN_W-1:0]   w_sel;
  logic [ACC_W-1:0]   w_acc_adj;
  logic               w_acc_unused_msb;
  logic               w_fits;

  // Channel select for the LOAD snapshot
  always_comb begin
    w_sel = total_cycles;
    case (r_ptr)
      2'd0:    w_sel = total_cycles;
      2'd1:    w_sel = uncondi_branch_num;
      2'd2:    w_sel = condi_branch_num;
      default: w_sel = bubble_num;
    endcase
  end

  // Add-3 correction on every accumulator digit >= 5, all digits in parallel
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < ACC_DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // The top accumulator bit is shifted out and can never be set for a 32-bit input
  assign w_acc_unused_msb = w_acc_adj[ACC_W-1];

  assign w_fits = (r_acc[ACC_W-1:OUT_W] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_acc   <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
      r_busy  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_bcd[c] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          r_bin   <= w_sel;
          r_acc   <= '0;
          r_cnt   <= CNT_W'(BIN_W - 1);
          r_state <= S_SHIFT;
        end

        S_SHIFT: begin
          r_acc <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= S_STORE;
          end
        end

        S_STORE: begin
          if (w_fits) begin
            r_bcd[r_ptr] <= r_acc[OUT_W-1:0];
            r_ovf[r_ptr] <= 1'b0;
          end else begin
            r_bcd[r_ptr] <= SAT_VALUE;
            r_ovf[r_ptr] <= 1'b1;
          end
          r_valid[r_ptr] <= 1'b1;
          r_ptr          <= r_ptr + PTR_W'(1);
          if (en) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign total_cycles_bcd       = r_bcd[0];
  assign uncondi_branch_num_bcd = r_bcd[1];
  assign condi_branch_num_bcd   = r_bcd[2];
  assign bubble_num_bcd         = r_bcd[3];
  assign bcd_valid              = r_valid;
  assign bcd_ovf                = r_ovf;
  assign busy                   = r_busy;

endmodule

// File: tb/tb_stat_bcd_conv.sv
// Scoreboard bench for stat_bcd_conv: expected conversions are queued when a channel is
// sampled and compared against the outputs when that channel's result lands.
module tb_stat_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] in_tc, in_ub, in_cb, in_bn;
  logic [31:0] o_tc, o_ub, o_cb, o_bn;
  logic [3:0]  o_valid, o_ovf;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  stat_bcd_conv dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .en                     (en),
    .total_cycles           (in_tc),
    .uncondi_branch_num     (in_ub),
    .condi_branch_num       (in_cb),
    .bubble_num             (in_bn),
    .total_cycles_bcd       (o_tc),
    .uncondi_branch_num_bcd (o_ub),
    .condi_branch_num_bcd   (o_cb),
    .bubble_num_bcd         (o_bn),
    .bcd_valid              (o_valid),
    .bcd_ovf                (o_ovf),
    .busy                   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference conversion by repeated division: {ovf, packed bcd}
  function automatic logic [32:0] ref_conv(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    if (v > 32'd99999999) return {1'b1, 32'h9999_9999};
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 32'd10);
      t = t / 32'd10;
    end
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] chan_in(input int ch);
    case (ch)
      0:       return in_tc;
      1:       return in_ub;
      2:       return in_cb;
      default: return in_bn;
    endcase
  endfunction

  typedef struct {
    int          ch;
    logic [31:0] bcd;
    logic        ovf;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         m_e;
  logic [32:0] m_conv;
  logic [31:0] m_bcd [4];
  logic [3:0]  m_valid;
  logic [3:0]  m_ovf;
  int          m_ptr;
  bit          m_active;
  int          m_k;
  int          m_stores;
  int          m_last_ch;
  bit          m_stored;

  task automatic check_all(input string tag);
    check_val({tag, "_tc"},    o_tc, m_bcd[0]);
    check_val({tag, "_ub"},    o_ub, m_bcd[1]);
    check_val({tag, "_cb"},    o_cb, m_bcd[2]);
    check_val({tag, "_bn"},    o_bn, m_bcd[3]);
    check_val({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
    check_val({tag, "_ovf"},   32'(o_ovf), 32'(m_ovf));
  endtask

  // Timing model: edge 0 enters LOAD, edge 1 samples the input, edge 34 lands the result
  always begin
    @(posedge clk);
    m_stored = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      for (int c = 0; c < 4; c++) m_bcd[c] = '0;
      m_valid  = '0;
      m_ovf    = '0;
      m_ptr    = 0;
      m_active = 1'b0;
      m_k      = 0;
      #1;
      check_all("rst");
      check_val("rst_busy", 32'(o_busy), 32'd0);
    end else begin
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_k      = 0;
        end
      end else begin
        m_k++;
        if (m_k == 1) begin
          m_conv = ref_conv(chan_in(m_ptr));
          sb_q.push_back('{ch: m_ptr, bcd: m_conv[31:0], ovf: m_conv[32]});
        end else if (m_k == 34) begin
          if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            m_bcd[m_e.ch]   = m_e.bcd;
            m_ovf[m_e.ch]   = m_e.ovf;
            m_valid[m_e.ch] = 1'b1;
            m_last_ch       = m_e.ch;
          end
          m_ptr    = (m_ptr + 1) % 4;
          m_stores++;
          m_stored = 1'b1;
          if (en) m_k = 0;
          else    m_active = 1'b0;
        end
      end
      #1;
      check_val("busy", 32'(o_busy), 32'(m_active));
      if (m_stored) check_all("store");
    end
  end

  task automatic wait_stores(input int n);
    int target;
    int budget;
    target = m_stores + n;
    budget = n * 34 + 80;
    while (m_stores < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (m_stores < target) check_val("store_timeout", 32'(m_stores), 32'(target));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'($urandom_range(0, 99999999));
      1:       return $urandom;
      2:       return 32'd99999999;
      3:       return 32'd100000000;
      4:       return 32'hFFFF_FFFF;
      5:       return 32'($urandom_range(0, 999));
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_stores  = 0;
    m_last_ch = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    in_tc = 32'd0;
    in_ub = 32'd7;
    in_cb = 32'd99999999;
    in_bn = 32'd1000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", 32'(o_busy), 32'd0);

    // First conversion of channel 0
    en = 1'b1;
    wait_stores(1);
    check_val("t1_tc",    o_tc, 32'h0000_0000);
    check_val("t1_valid", 32'(o_valid), 32'h1);
    check_val("t1_ovf",   32'(o_ovf), 32'h0);

    // Full sweep of mixed values
    in_tc = 32'd12345678;
    wait_stores(4);
    check_val("t2_tc",    o_tc, 32'h1234_5678);
    check_val("t2_ub",    o_ub, 32'h0000_0007);
    check_val("t2_cb",    o_cb, 32'h9999_9999);
    check_val("t2_bn",    o_bn, 32'h0000_1000);
    check_val("t2_valid", 32'(o_valid), 32'hF);
    check_val("t2_ovf",   32'(o_ovf), 32'h0);

    // Saturation on channel 2 and recovery
    in_cb = 32'd100000000;
    wait_stores(2);
    check_val("t3_sat9_cb",  o_cb, 32'h9999_9999);
    check_val("t3_sat9_ovf", 32'(o_ovf[2]), 32'd1);
    in_cb = 32'hFFFF_FFFF;
    wait_stores(4);
    check_val("t3_max_cb",  o_cb, 32'h9999_9999);
    check_val("t3_max_ovf", 32'(o_ovf[2]), 32'd1);
    in_cb = 32'd5;
    wait_stores(4);
    check_val("t3_rec_cb",  o_cb, 32'h0000_0005);
    check_val("t3_rec_ovf", 32'(o_ovf[2]), 32'd0);

    // Random and boundary sweeps, aligned to start at channel 0
    wait_stores(1);
    for (int s = 0; s < 3; s++) begin
      in_tc = pick();
      in_ub = pick();
      in_cb = pick();
      in_bn = pick();
      wait_stores(4);
    end

    // Input change mid-SHIFT does not disturb the in-flight conversion
    in_tc = 32'd250;
    repeat (11) @(negedge clk);
    in_tc = 32'd999;
    wait_stores(1);
    check_val("t4_old_tc", o_tc, 32'h0000_0250);
    wait_stores(4);
    check_val("t4_new_tc", o_tc, 32'h0000_0999);

    // Drop en during channel 1 SHIFT: it still stores, then the FSM idles
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_stores(1);
    check_val("t5_last_ch", 32'(m_last_ch), 32'd1);
    check_val("t5_busy_fall", 32'(o_busy), 32'd0);
    in_cb = 32'd42;
    repeat (60) @(negedge clk);
    check_all("t5_idle");
    check_val("t5_idle_busy", 32'(o_busy), 32'd0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t5_resume_busy", 32'(o_busy), 32'd1);
    wait_stores(1);
    check_val("t5_resume_cb", o_cb, 32'h0000_0042);

    // Synchronous reset mid-SHIFT of channel 3
    in_bn = 32'd31415;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("t6_tc",    o_tc, 32'h0);
    check_val("t6_bn",    o_bn, 32'h0);
    check_val("t6_valid", 32'(o_valid), 32'h0);
    check_val("t6_busy",  32'(o_busy), 32'd0);
    wait_stores(1);
    check_val("t6_restart_valid", 32'(o_valid), 32'h1);
    check_val("t6_restart_tc",    o_tc, 32'h0000_0999);
    check_val("t6_restart_bn",    o_bn, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stat_bcd_conv.md
Name: stat_bcd_conv

Overview:
- Multi-cycle binary-to-BCD converter for the four pipeline statistics counters: total cycles, unconditional branches, conditional branches and bubbles.
- Sits directly upstream of the seven-segment display driver. Feeds it registered 8-digit packed-BCD words, replacing four parallel combinational converters.
- One shared shift-add-3 (double-dabble) datapath is time-multiplexed round-robin over the four channels.

Parameters:
- NUM_DIGITS, 8, BCD digits presented on each output (32-bit packed). Fixed; not intended for override.
- SAT_VALUE, 32'h9999_9999, value driven on an output when its binary input exceeds 8 decimal digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- en  in  1  conversion enable; low freezes outputs after the current conversion completes
- total_cycles  in  32  binary, channel 0
- uncondi_branch_num  in  32  binary, channel 1
- condi_branch_num  in  32  binary, channel 2
- bubble_num  in  32  binary, channel 3
- total_cycles_bcd  out  32  packed BCD, channel 0, digit 7 in [31:28]
- uncondi_branch_num_bcd  out  32  packed BCD, channel 1
- condi_branch_num_bcd  out  32  packed BCD, channel 2
- bubble_num_bcd  out  32  packed BCD, channel 3
- bcd_valid  out  4  per-channel flag: output holds at least one completed conversion
- bcd_ovf  out  4  per-channel flag: last conversion saturated
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset:
  - Single clock domain; reset sampled only on the rising edge of clk.
  - rst_n=0 clears all four BCD outputs to 0, bcd_valid=0, bcd_ovf=0, busy=0, channel pointer=0, FSM=IDLE.
  - Reset takes effect in the middle of a conversion; the partial result is discarded.
- FSM states: IDLE, LOAD, SHIFT, STORE.
  - IDLE: if en=1, go to LOAD next cycle; otherwise stay.
  - LOAD, 1 cycle:
    - Snapshot the input selected by the channel pointer into a 32-bit shift register.
    - Clear the 40-bit (10-digit) BCD accumulator.
    - Bit counter = 31.
  - SHIFT, exactly 32 cycles:
    - In each cycle, first add 3 to every accumulator digit >=5 (all 10 digits in parallel).
    - Then shift {accumulator, binary} left by 1; the binary MSB enters accumulator bit 0.
    - Counter decrements; leave SHIFT after the cycle with counter=0.
  - STORE, 1 cycle:
    - If accumulator digits 9..8 are both zero, the output for the current channel takes digits 7..0 and its bcd_ovf bit goes to 0.
    - Otherwise the output takes SAT_VALUE and its bcd_ovf bit goes to 1.
    - That channel's bcd_valid bit is set; the pointer advances 0->1->2->3->0.
    - Next state is LOAD if en=1, else IDLE.
- Timing:
  - Latency is 34 cycles from the LOAD edge to updated output visibility.
  - A full sweep of all four channels takes 136 cycles.
  - The output updates on the clock edge that ends STORE and is stable for the following 135 cycles.
- Inputs are sampled only in LOAD. Changes during SHIFT or STORE do not affect the in-flight conversion.
- Outputs change only in STORE or on reset. They are never glitched by the datapath: output registers are separate from the accumulator.
- en falling during LOAD or SHIFT: the current conversion completes and stores, then the FSM goes to IDLE. The pointer is preserved, so resume continues with the next channel.
- busy=1 in LOAD, SHIFT and STORE.
- Widths:
  - Accumulator is 40 bits, so no internal overflow is possible for any 32-bit input (max 4294967295).
  - Digit compare uses unsigned >=5, and add-3 is 4-bit with no carry out.

Test Plan:
- Reset, then en=1 with total_cycles=0 -> after 34 cycles total_cycles_bcd=32'h0000_0000, bcd_valid=4'b0001, bcd_ovf=0.
- Set channels to 12345678, 7, 99999999 and 1000 -> after 136 cycles the outputs are 32'h1234_5678, 32'h0000_0007, 32'h9999_9999 and 32'h0000_1000; bcd_valid=4'hF; bcd_ovf=4'h0.
- condi_branch_num=100000000, and separately 32'hFFFF_FFFF -> condi_branch_num_bcd=32'h9999_9999 with bcd_ovf[2]=1; then input=5 -> next sweep gives 32'h0000_0005 and bcd_ovf[2]=0.
- Change total_cycles from 250 to 999 on cycle 10 of SHIFT for channel 0 -> this conversion stores 32'h0000_0250; the next sweep stores 32'h0000_0999.
- Drop en during SHIFT of channel 1 -> channel 1 still stores; busy falls 1 cycle after STORE; no further updates; re-raising en starts LOAD of channel 2.
- Assert rst_n=0 for 1 cycle mid-SHIFT of channel 3 -> the next edge shows all outputs=0, bcd_valid=0, busy=0; conversion restarts at channel 0 once en=1.
